fir_out_decim: RTL and testbench
================================

# fir_out_decim

Downstream stage of the 4-tap FIR (`TOP_LEVEL`). It takes the FIR's full-precision output word and decimates it by a selectable factor of 1, 2, 4 or 8 using boxcar accumulation. Each accumulated result is right-shifted with rounding, then saturated back to SIZE bits. Results are buffered in a small first-word-fall-through FIFO and drained over a valid/ready handshake to the sink.

## Interface

Parameters
- SIZE, 8: FIR sample width. FIR output width is 2*SIZE+2.
- DEPTH, 4: output FIFO entries. Must be a power of 2, at least 2.

Ports
- CLK  in  1: clock, rising-edge.
- RST_N  in  1: reset, asynchronous, active-low.
- IN_VALID  in  1: FIR_OUT holds a new sample this cycle.
- FIR_OUT  in  2*SIZE+2: unsigned FIR result (the FIR's OUTPUT bus).
- DECIM  in  2: decimation factor N = 1 << DECIM, so 1/2/4/8.
- SHIFT  in  5: right-shift applied to the frame sum. Legal range 0..2*SIZE+4.
- CLR_FLAGS  in  1: synchronous clear of the sticky flags.
- OUT_DATA  out  SIZE: FIFO head.
- OUT_VALID  out  1: FIFO not empty.
- OUT_READY  in  1: sink accepts OUT_DATA.
- OVERFLOW  out  1: sticky; a result was dropped because the FIFO was full.
- SAT_FLAG  out  1: sticky; a result was clipped to 2^SIZE-1.

## Operation

- Accumulator ACC is 2*SIZE+5 bits wide. It cannot overflow, since 8 × max FIR_OUT fits.
- Frame counter CNT[2:0] has two states:
  - IDLE: CNT=0, ACC=0.
  - ACC: 0 < CNT < N.
- DECIM and SHIFT are latched into NLAT and SLAT when a sample is accepted in IDLE. Changes mid-frame take effect at the next frame.
- Each accepted sample (IN_VALID=1): SUM = ACC + FIR_OUT.
  - If CNT = NLAT-1, the frame is complete. SUM goes to the result stage, ACC←0, CNT←0 (return to IDLE).
  - Otherwise ACC←SUM, CNT←CNT+1.
  - When N=1, every sample completes a frame.
- Result stage, registered:
  - Rounding: R = (SUM + (SLAT>0 ? 1<<(SLAT-1) : 0)) >> SLAT, round-half-up.
  - Saturation: if R > 2^SIZE-1, store 2^SIZE-1 and set SAT_FLAG. Otherwise store R[SIZE-1:0].
  - RES_VALID is asserted for one cycle.
- FIFO write happens on the edge after RES_VALID.
  - Push is accepted if the FIFO is not full, or if a pop happens on the same edge.
  - Otherwise the result is dropped and OVERFLOW is set. FIFO contents are unchanged.
- Pop happens on OUT_VALID && OUT_READY. OUT_DATA is the head entry (first-word-fall-through).
- Pointers wrap modulo DEPTH. The occupancy counter is 0..DEPTH.
- Sticky flags:
  - Cleared by reset or by CLR_FLAGS.
  - If CLR_FLAGS and a new set event occur on the same edge, the set wins.
- IN_VALID=0 holds ACC and CNT unchanged. There is no timeout and no partial-frame flush.

## Timing

- Reset (RST_N low, asynchronous) clears:
  - CNT=0, ACC=0, NLAT=1, SLAT=0, RES_VALID=0.
  - FIFO empty, so OUT_VALID=0 and OUT_DATA=0.
  - OVERFLOW=0, SAT_FLAG=0.
- Reset mid-frame discards the partial frame and all FIFO contents. The first sample after RST_N rises starts a new frame.
- Latency: the last sample of a frame is accepted at edge k.
  - RES_VALID is high after edge k.
  - The FIFO write occurs at edge k+1.
  - OUT_VALID rises after edge k+1 if the FIFO was empty.
- Throughput: one sample per cycle sustained. At N=1, one result per cycle with no bubbles while OUT_READY=1.
- Pop at edge t: the next entry appears on OUT_DATA after t. OUT_VALID falls after t if the FIFO becomes empty.
- Full FIFO with a push and pop on the same edge: both occur, and occupancy stays at DEPTH.
- Empty FIFO with a push: the value is visible on the next cycle. The same-cycle bypass is not allowed.
- OUT_DATA must hold stable while OUT_VALID=1 and OUT_READY=0.

## Test plan

- Reset and pass-through: reset with RST_N low, then DECIM=0, SHIFT=0, FIR_OUT=25 for one cycle, OUT_READY=1.
  - Required: OUT_DATA=25 with OUT_VALID=1 two edges after acceptance.
  - Required: all outputs are 0 during reset.
- Decimate by 4: DECIM=2, SHIFT=2, samples 10, 11, 12, 13 on consecutive cycles.
  - Required: a single result 12, since (46+2)>>2.
  - Required: samples 1, 1, 2, 2 then give (6+2)>>2 = 2.
- Saturation: SIZE=8, DECIM=0, SHIFT=0, FIR_OUT=300.
  - Required: OUT_DATA=255, SAT_FLAG=1.
  - Required: a pulse on CLR_FLAGS clears SAT_FLAG.
- FIFO full: DEPTH=4, OUT_READY=0, DECIM=0, SHIFT=0, five samples 1..5.
  - Required: OVERFLOW=1 and 4 entries held.
  - Required: then OUT_READY=1 drains 1, 2, 3, 4 and the 5 is never seen.
- Simultaneous push and pop at full: FIFO full, OUT_READY=1, a new sample 9 arrives.
  - Required: occupancy stays 4, OVERFLOW stays 0, and 9 is drained last.
- Mid-frame changes:
  - DECIM=3 and sample stream 8, 8, 8, then RST_N pulsed low. Required: FIFO empty. Then 8 samples of 8 with SHIFT=3 give 8.
  - DECIM changed mid-frame. Required: the current frame still uses the old N.

Source files
------------

// File: rtl/fir_out_decim.sv
// Boxcar decimator (N = 1/2/4/8) for the 4-tap FIR output: round-half-up shift,
// saturate to SIZE bits, buffer in a first-word-fall-through FIFO drained by valid/ready.
module fir_out_decim #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  input  logic [2*SIZE+1:0]   FIR_OUT,
  input  logic [1:0]          DECIM,
  input  logic [4:0]          SHIFT,
  input  logic                CLR_FLAGS,
  output logic [SIZE-1:0]     OUT_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                OVERFLOW,
  output logic                SAT_FLAG
);

  localparam int unsigned AW = 2*SIZE + 5;
  localparam int unsigned RW = AW + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]   r_acc;
  logic [2:0]      r_cnt;
  logic [1:0]      r_dlat;
  logic [4:0]      r_slat;
  logic            r_res_valid;
  logic [SIZE-1:0] r_res;
  logic [SIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CW-1:0]   r_count;
  logic [SIZE-1:0] r_out_data;
  logic            r_out_valid;
  logic            r_ovf;
  logic            r_sat;

  logic            w_idle;
  logic [1:0]      w_dec;
  logic [4:0]      w_shift;
  logic [2:0]      w_nm1;
  logic            w_last;
  logic            w_frame_done;
  logic [AW-1:0]   w_sum;
  logic [RW-1:0]   w_rnd;
  logic [RW-1:0]   w_rsh;
  logic            w_clip;
  logic [SIZE-1:0] w_res;
  logic            w_pop;
  logic            w_full;
  logic            w_push;
  logic            w_drop;
  logic [PW-1:0]   w_rp_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [SIZE-1:0] w_head_nxt;

  // A frame's N and shift come from the inputs on its first sample, latched copies afterwards.
  assign w_idle       = (r_cnt == 3'd0);
  assign w_dec        = w_idle ? DECIM : r_dlat;
  assign w_shift      = w_idle ? SHIFT : r_slat;
  assign w_nm1        = 3'((4'd1 << w_dec) - 4'd1);
  assign w_last       = (r_cnt == w_nm1);
  assign w_frame_done = IN_VALID & w_last;
  assign w_sum        = r_acc + AW'(FIR_OUT);

  assign w_rnd  = (w_shift == 5'd0) ? '0 : (RW'(1) << (w_shift - 5'd1));
  assign w_rsh  = (RW'(w_sum) + w_rnd) >> w_shift;
  assign w_clip = |w_rsh[RW-1:SIZE];
  assign w_res  = w_clip ? '1 : w_rsh[SIZE-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_dlat <= '0;
      r_slat <= '0;
    end else if (IN_VALID) begin
      if (w_idle) begin
        r_dlat <= DECIM;
        r_slat <= SHIFT;
      end
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_res_valid <= 1'b0;
      r_res       <= '0;
    end else begin
      r_res_valid <= w_frame_done;
      if (w_frame_done) r_res <= w_res;
    end
  end

  // A full FIFO still takes the push when the head leaves on the same edge.
  assign w_pop     = r_out_valid & OUT_READY;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push    = r_res_valid & (~w_full | w_pop);
  assign w_drop    = r_res_valid & ~w_push;
  assign w_rp_nxt  = r_rp + PW'(w_pop);
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_head_nxt = '0;
    if (w_cnt_nxt != '0) begin
      if (w_push && (r_wp == w_rp_nxt)) w_head_nxt = r_res;
      else                              w_head_nxt = r_mem[w_rp_nxt];
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wp] <= r_res;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_wp        <= r_wp + PW'(w_push);
      r_rp        <= w_rp_nxt;
      r_count     <= w_cnt_nxt;
      r_out_data  <= w_head_nxt;
      r_out_valid <= (w_cnt_nxt != '0);
      r_ovf       <= w_drop | (r_ovf & ~CLR_FLAGS);
      r_sat       <= (w_frame_done & w_clip) | (r_sat & ~CLR_FLAGS);
    end
  end

  assign OUT_DATA  = r_out_data;
  assign OUT_VALID = r_out_valid;
  assign OVERFLOW  = r_ovf;
  assign SAT_FLAG  = r_sat;

endmodule

// File: tb/tb_fir_out_decim.sv
// Bench for fir_out_decim: directed vector table, then random traffic against a queue-based model.
module tb_fir_out_decim;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;
  localparam int FW    = 2*SIZE + 2;
  localparam int MAXV  = (1 << SIZE) - 1;

  logic          CLK;
  logic          RST_N;
  logic          IN_VALID;
  logic [FW-1:0] FIR_OUT;
  logic [1:0]    DECIM;
  logic [4:0]    SHIFT;
  logic          CLR_FLAGS;
  logic [SIZE-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic          OVERFLOW;
  logic          SAT_FLAG;

  fir_out_decim #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .FIR_OUT(FIR_OUT),
    .DECIM(DECIM), .SHIFT(SHIFT), .CLR_FLAGS(CLR_FLAGS),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OVERFLOW(OVERFLOW), .SAT_FLAG(SAT_FLAG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit rst; bit iv; int fir; int dec; int sh; bit rdy; bit clr;
    bit ev; int ed; bit eovf; bit esat;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  // reference model state
  longint m_acc;
  int     m_cnt, m_n, m_s;
  int     m_q[$];
  bit     m_pv;
  int     m_pval;
  bit     m_ovf, m_sat;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void add(bit rst, bit iv, int fir, int dec, int sh, bit rdy, bit clr,
                              bit ev, int ed, bit eovf, bit esat);
    vec_t v;
    v.rst = rst; v.iv = iv; v.fir = fir; v.dec = dec; v.sh = sh; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.eovf = eovf; v.esat = esat;
    tbl.push_back(v);
  endfunction

  task automatic drive(bit rst, bit iv, int fir, int dec, int sh, bit rdy, bit clr);
    RST_N     = ~rst;
    IN_VALID  = iv;
    FIR_OUT   = FW'(fir);
    DECIM     = 2'(dec);
    SHIFT     = 5'(sh);
    OUT_READY = rdy;
    CLR_FLAGS = clr;
  endtask

  function automatic void model_reset();
    m_acc = 0; m_cnt = 0; m_n = 1; m_s = 0;
    m_q.delete(); m_pv = 0; m_pval = 0; m_ovf = 0; m_sat = 0;
  endfunction

  // One clock edge of the specified behaviour, using the inputs present before the edge.
  function automatic void model_edge(bit iv, int fir, int dec, int sh, bit rdy, bit clr);
    bit     new_ovf = 0;
    bit     new_sat = 0;
    longint sum, r;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (m_pv) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pval);
      else new_ovf = 1;
    end
    m_pv = 0;
    if (iv) begin
      if (m_cnt == 0) begin
        m_n = 1 << dec;
        m_s = sh;
      end
      sum = m_acc + fir;
      if (m_cnt == m_n - 1) begin
        r = (sum + ((m_s > 0) ? (longint'(1) << (m_s - 1)) : 0)) >> m_s;
        if (r > MAXV) begin
          m_pval = MAXV;
          new_sat = 1;
        end else begin
          m_pval = int'(r);
        end
        m_pv  = 1;
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc = sum;
        m_cnt++;
      end
    end
    m_ovf = new_ovf | (m_ovf & !clr);
    m_sat = new_sat | (m_sat & !clr);
  endfunction

  initial begin
    vec_t v;
    int   fir, dec, sh;
    bit   iv, rdy, clr, rst;

    // pass-through
    add(0,1,25,0,0,1,0, 0,0,0,0);
    add(0,0,0,0,0,1,0,  1,25,0,0);
    add(0,0,0,0,0,1,0,  0,0,0,0);
    // decimate by 4, shift 2
    add(0,1,10,2,2,1,0, 0,0,0,0);
    add(0,1,11,2,2,1,0, 0,0,0,0);
    add(0,1,12,2,2,1,0, 0,0,0,0);
    add(0,1,13,2,2,1,0, 0,0,0,0);
    add(0,1,1,2,2,1,0,  1,12,0,0);
    add(0,1,1,2,2,1,0,  0,0,0,0);
    add(0,1,2,2,2,1,0,  0,0,0,0);
    add(0,1,2,2,2,1,0,  0,0,0,0);
    add(0,0,0,2,2,1,0,  1,2,0,0);
    add(0,0,0,2,2,0,0,  1,2,0,0);
    add(0,0,0,2,2,1,0,  0,0,0,0);
    // saturation and flag clear, head held while not ready
    add(0,1,300,0,0,1,0, 0,0,0,1);
    add(0,0,0,0,0,0,0,   1,255,0,1);
    add(0,0,0,0,0,0,1,   1,255,0,0);
    add(0,0,0,0,0,1,0,   0,0,0,0);
    // fill past full with the sink stalled
    add(0,1,1,0,0,0,0, 0,0,0,0);
    add(0,1,2,0,0,0,0, 1,1,0,0);
    add(0,1,3,0,0,0,0, 1,1,0,0);
    add(0,1,4,0,0,0,0, 1,1,0,0);
    add(0,1,5,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0,0,0, 1,1,1,0);
    add(0,0,0,0,0,1,0, 1,2,1,0);
    add(0,0,0,0,0,1,0, 1,3,1,0);
    add(0,0,0,0,0,1,0, 1,4,1,0);
    add(0,0,0,0,0,1,0, 0,0,1,0);
    // refill, then push and pop together at full
    add(0,1,5,0,0,0,1, 0,0,0,0);
    add(0,1,6,0,0,0,0, 1,5,0,0);
    add(0,1,7,0,0,0,0, 1,5,0,0);
    add(0,1,8,0,0,0,0, 1,5,0,0);
    add(0,1,9,0,0,0,0, 1,5,0,0);
    add(0,0,0,0,0,1,0, 1,6,0,0);
    add(0,0,0,0,0,1,0, 1,7,0,0);
    add(0,0,0,0,0,1,0, 1,8,0,0);
    add(0,0,0,0,0,1,0, 1,9,0,0);
    add(0,0,0,0,0,1,0, 0,0,0,0);
    // partial frame killed by reset, then a full N=8 frame
    add(0,1,8,3,3,1,0, 0,0,0,0);
    add(0,1,8,3,3,1,0, 0,0,0,0);
    add(0,1,8,3,3,1,0, 0,0,0,0);
    add(1,0,0,3,3,1,0, 0,0,0,0);
    for (int i = 0; i < 8; i++) add(0,1,8,3,3,1,0, 0,0,0,0);
    add(0,0,0,3,3,1,0, 1,8,0,0);
    add(0,0,0,3,3,1,0, 0,0,0,0);
    // DECIM change mid-frame keeps the old N
    add(0,1,10,1,0,1,0, 0,0,0,0);
    add(0,1,20,0,0,1,0, 0,0,0,0);
    add(0,1,7,0,0,1,0,  1,30,0,0);
    add(0,0,0,0,0,1,0,  1,7,0,0);
    add(0,0,0,0,0,1,0,  0,0,0,0);

    // reset: outputs must be zero while RST_N is low
    drive(1,0,0,0,0,0,0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", int'(OUT_VALID), 0);
    check("rst_data",  int'(OUT_DATA),  0);
    check("rst_ovf",   int'(OVERFLOW),  0);
    check("rst_sat",   int'(SAT_FLAG),  0);

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.rst, v.iv, v.fir, v.dec, v.sh, v.rdy, v.clr);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d_valid", i), int'(OUT_VALID), int'(v.ev));
      check($sformatf("vec%0d_data", i),  int'(OUT_DATA),  v.ed);
      check($sformatf("vec%0d_ovf", i),   int'(OVERFLOW),  int'(v.eovf));
      check($sformatf("vec%0d_sat", i),   int'(SAT_FLAG),  int'(v.esat));
    end

    // random traffic against the model
    drive(1,0,0,0,0,0,0);
    @(posedge CLK);
    #1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      fir = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 400))
                                        : int'($urandom_range(0, (1 << FW) - 1));
      dec = int'($urandom_range(0, 3));
      sh  = int'($urandom_range(0, 2*SIZE + 4));
      rdy = ($urandom_range(0, 9) < 5);
      clr = ($urandom_range(0, 19) == 0);
      drive(rst, iv, fir, dec, sh, rdy, clr);
      if (rst) model_reset();
      else     model_edge(iv, fir, dec, sh, rdy, clr);
      @(posedge CLK);
      #1;
      check("rnd_valid", int'(OUT_VALID), int'(m_q.size() > 0));
      check("rnd_data",  int'(OUT_DATA),  (m_q.size() > 0) ? m_q[0] : 0);
      check("rnd_ovf",   int'(OVERFLOW),  int'(m_ovf));
      check("rnd_sat",   int'(SAT_FLAG),  int'(m_sat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
